i2c_pwm_regs: RTL and testbench



---
 rtl/i2c_pwm_pkg.sv | 33 +++
 rtl/i2c_pwm_regs_sync.sv | 43 ++++
 rtl/i2c_pwm_regs.sv | 178 +++++++++++++++++
 tb/tb_i2c_pwm_regs.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pwm_pkg.sv
// Shared types and constants for the I2C-controlled PWM duty register block.
package i2c_pwm_pkg;

  localparam int NUM_CH = 8;

  // Bus-level acknowledge values as seen on SDA.
  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  // Power-on duty values, channel 0 in the low byte.
  localparam logic [NUM_CH-1:0][7:0] RESET_VALS = {
    8'd255, 8'd200, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20, 8'd1
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  // Register pointer advance; 3-bit arithmetic wraps 7 -> 0.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/i2c_pwm_regs_sync.sv
// Synchronizer for one open-drain I2C line: level plus one-cycle edge pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Sync chain and history flop; lines idle high so reset to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '1;
      r_hist  <= 1'b1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist  <= w_synced;
      r_level <= w_synced;
      r_rise  <= w_synced & ~r_hist;
      r_fall  <= ~w_synced & r_hist;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_pwm_regs.sv
// I2C target owning the eight PWM duty registers, with auto-incrementing pointer.
module i2c_pwm_regs
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [63:0] values,
  output logic        wr_strobe,
  output logic [2:0]  wr_index
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_scl_edge, w_start, w_stop;

  state_t                   r_state;
  logic [3:0]               r_bitcnt;
  logic [7:0]               r_shift;
  logic                     r_rw;
  logic                     r_mack;
  logic [2:0]               r_ptr;
  logic [NUM_CH-1:0][7:0]   r_vals;
  logic                     r_oe;
  logic                     r_strobe;
  logic [2:0]               r_windex;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (scl_in),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // An SDA edge coinciding with an SCL edge is treated as data, never START/STOP.
  assign w_scl_edge = w_scl_rise | w_scl_fall;
  assign w_start    = w_sda_fall & w_scl_lvl & ~w_scl_edge;
  assign w_stop     = w_sda_rise & w_scl_lvl & ~w_scl_edge;

  // Protocol FSM, shift register, pointer and duty register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 8'd0;
      r_rw     <= 1'b0;
      r_mack   <= NACK_BIT;
      r_ptr    <= 3'd0;
      r_vals   <= RESET_VALS;
      r_oe     <= 1'b0;
      r_strobe <= 1'b0;
      r_windex <= 3'd0;
    end else begin
      r_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_oe     <= 1'b0;
        r_bitcnt <= 4'd0;
      end else if (w_start) begin
        // Repeated start keeps the pointer; any partial byte is dropped.
        r_state  <= ST_ADDR;
        r_oe     <= 1'b0;
        r_bitcnt <= 4'd0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            r_shift  <= {r_shift[6:0], w_sda_lvl};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          ST_RDATA_ACK: r_mack <= w_sda_lvl;
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_ADDR: begin
            if (r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd0;
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state <= ST_ADDR_ACK;
                r_rw    <= r_shift[0];
                r_oe    <= ~ACK_BIT;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (r_rw) begin
              // First read bit goes out on the fall that ends the ACK.
              r_state  <= ST_RDATA;
              r_shift  <= r_vals[r_ptr];
              r_oe     <= ~r_vals[r_ptr][7];
              r_bitcnt <= 4'd1;
            end else begin
              r_state  <= ST_PTR;
              r_oe     <= 1'b0;
              r_bitcnt <= 4'd0;
            end
          end
          ST_PTR: begin
            if (r_bitcnt == 4'd8) begin
              r_ptr    <= r_shift[2:0];
              r_state  <= ST_PTR_ACK;
              r_oe     <= ~ACK_BIT;
              r_bitcnt <= 4'd0;
            end
          end
          ST_PTR_ACK: begin
            r_state <= ST_WDATA;
            r_oe    <= 1'b0;
          end
          ST_WDATA: begin
            if (r_bitcnt == 4'd8) begin
              r_vals[r_ptr] <= r_shift;
              r_strobe      <= 1'b1;
              r_windex      <= r_ptr;
              r_ptr         <= ptr_inc(r_ptr);
              r_state       <= ST_WDATA_ACK;
              r_oe          <= ~ACK_BIT;
              r_bitcnt      <= 4'd0;
            end
          end
          ST_WDATA_ACK: begin
            r_state <= ST_WDATA;
            r_oe    <= 1'b0;
          end
          ST_RDATA: begin
            if (r_bitcnt == 4'd8) begin
              // Byte done: release SDA so the controller can drive its ACK.
              r_oe     <= 1'b0;
              r_ptr    <= ptr_inc(r_ptr);
              r_state  <= ST_RDATA_ACK;
              r_bitcnt <= 4'd0;
            end else begin
              r_shift  <= {r_shift[6:0], 1'b0};
              r_oe     <= ~r_shift[6];
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          ST_RDATA_ACK: begin
            if (r_mack == ACK_BIT) begin
              r_state  <= ST_RDATA;
              r_shift  <= r_vals[r_ptr];
              r_oe     <= ~r_vals[r_ptr][7];
              r_bitcnt <= 4'd1;
            end else begin
              r_state <= ST_WAIT_STOP;
              r_oe    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_oe;
  assign values    = r_vals;
  assign wr_strobe = r_strobe;
  assign wr_index  = r_windex;

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// Scoreboard bench for i2c_pwm_regs: a bit-banged I2C controller drives the
// bus, expected register writes are queued and checked on each wr_strobe.
module tb_i2c_pwm_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_drv = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic [63:0] values;
  logic        wr_strobe;
  logic [2:0]  wr_index;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] ev[8];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_strb = 0;
  int         n_oe   = 0;

  // Open-drain bus: either side can pull low.
  assign sda_bus = sda_oe ? 1'b0 : sda_drv;

  always #5 clk = ~clk;

  i2c_pwm_regs #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .values    (values),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk = n_chk + 1;
    if (act === exp_v) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
  endtask

  function automatic logic [63:0] ev_bus();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = ev[i];
    return r;
  endfunction

  task automatic reset_model();
    ev = '{8'd1, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200, 8'd255};
  endtask

  task automatic expect_wr(input logic [2:0] idx, input logic [7:0] d);
    wr_t e;
    e.idx  = idx;
    e.data = d;
    exp_wr.push_back(e);
    ev[idx] = d;
  endtask

  // Quarter SCL period; SCL period is 32 clk.
  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic start_c();
    sda_drv = 1'b1; q();
    scl = 1'b1;     q();
    sda_drv = 1'b0; q();
    scl = 1'b0;     q();
  endtask

  task automatic stop_c();
    sda_drv = 1'b0; q();
    scl = 1'b1;     q();
    sda_drv = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    sda_drv = b; q();
    scl = 1'b1;  q();
    q();
    scl = 1'b0;  q();
  endtask

  task automatic rbit(output logic b);
    sda_drv = 1'b1; q();
    scl = 1'b1;     q();
    b = sda_bus;    q();
    scl = 1'b0;     q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
  endtask

  // Write monitor: each strobe must match the oldest queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && wr_strobe) begin
        n_strb = n_strb + 1;
        if (exp_wr.size() == 0) begin
          n_chk = n_chk + 1;
          $display("FAIL unexpected_strobe: index %0d, no write expected", wr_index);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_index", {61'd0, wr_index}, {61'd0, e.idx});
          chk("wr_data", {56'd0, values[int'(e.idx)*8 +: 8]}, {56'd0, e.data});
        end
      end
    end
  end

  // Counts assertions of sda_oe so silent phases can be verified.
  initial begin
    logic d;
    d = 1'b0;
    forever begin
      @(negedge clk);
      if (sda_oe && !d) n_oe = n_oe + 1;
      d = sda_oe;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         s0, o0;

    reset_model();
    repeat (4) @(negedge clk);
    chk("reset_values", values, ev_bus());
    chk("reset_sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("reset_strobe", {63'd0, wr_strobe}, 64'd0);
    chk("reset_index", {61'd0, wr_index}, 64'd0);
    rst = 1'b0;
    q();

    // Write 0x7F to channel 3.
    s0 = n_strb;
    start_c();
    wbyte(8'h84, a); chk("t1_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h03, a); chk("t1_ptr_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd3, 8'h7F);
    wbyte(8'h7F, a); chk("t1_data_ack", {63'd0, a}, 64'd0);
    stop_c(); q();
    chk("t1_strobes", 64'(n_strb - s0), 64'd1);
    chk("t1_values", values, ev_bus());

    // Readback of channels 5 and 6 through a repeated start.
    start_c();
    wbyte(8'h84, a); chk("t3_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h05, a); chk("t3_ptr_ack", {63'd0, a}, 64'd0);
    start_c();
    wbyte(8'h85, a); chk("t3_raddr_ack", {63'd0, a}, 64'd0);
    rbyte(d, 1'b0);  chk("t3_read0", {56'd0, d}, 64'h64);
    rbyte(d, 1'b1);  chk("t3_read1", {56'd0, d}, 64'hC8);
    chk("t3_released_after_nack", {63'd0, sda_oe}, 64'd0);
    stop_c(); q();

    // Auto-increment across the 7 -> 0 wrap.
    s0 = n_strb;
    start_c();
    wbyte(8'h84, a); chk("t2_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h06, a); chk("t2_ptr_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd6, 8'hA1);
    wbyte(8'hA1, a); chk("t2_d0_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd7, 8'hA2);
    wbyte(8'hA2, a); chk("t2_d1_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd0, 8'hA3);
    wbyte(8'hA3, a); chk("t2_d2_ack", {63'd0, a}, 64'd0);
    stop_c(); q();
    chk("t2_strobes", 64'(n_strb - s0), 64'd3);
    chk("t2_values", values, ev_bus());

    // Wrong address: target stays silent.
    s0 = n_strb; o0 = n_oe;
    start_c();
    wbyte(8'h90, a); chk("t4_addr_nack", {63'd0, a}, 64'd1);
    wbyte(8'h00, a); chk("t4_b1_nack", {63'd0, a}, 64'd1);
    wbyte(8'h55, a); chk("t4_b2_nack", {63'd0, a}, 64'd1);
    stop_c(); q();
    chk("t4_no_oe", 64'(n_oe - o0), 64'd0);
    chk("t4_no_strobe", 64'(n_strb - s0), 64'd0);
    chk("t4_values", values, ev_bus());

    // Aborted data byte, then a normal transaction.
    s0 = n_strb;
    start_c();
    wbyte(8'h84, a); chk("t5_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h02, a); chk("t5_ptr_ack", {63'd0, a}, 64'd0);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    stop_c(); q();
    chk("t5_no_strobe", 64'(n_strb - s0), 64'd0);
    chk("t5_values", values, ev_bus());
    start_c();
    wbyte(8'h84, a); chk("t5b_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h02, a); chk("t5b_ptr_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd2, 8'h33);
    wbyte(8'h33, a); chk("t5b_data_ack", {63'd0, a}, 64'd0);
    stop_c(); q();
    chk("t5b_values", values, ev_bus());

    // Reset while the target drives a 0 (bit 7 of channel 1 = 20).
    start_c();
    wbyte(8'h84, a); chk("t6_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h01, a); chk("t6_ptr_ack", {63'd0, a}, 64'd0);
    start_c();
    wbyte(8'h85, a); chk("t6_raddr_ack", {63'd0, a}, 64'd0);
    sda_drv = 1'b1; q();
    scl = 1'b1;     q();
    chk("t6_driving_zero", {63'd0, sda_oe}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_model();
    chk("t6_sda_oe_after_rst", {63'd0, sda_oe}, 64'd0);
    chk("t6_values_after_rst", values, ev_bus());
    rst = 1'b0;
    q();

    // Target recovers on the next START.
    start_c();
    wbyte(8'h84, a); chk("t7_addr_ack", {63'd0, a}, 64'd0);
    wbyte(8'h00, a); chk("t7_ptr_ack", {63'd0, a}, 64'd0);
    expect_wr(3'd0, 8'h5A);
    wbyte(8'h5A, a); chk("t7_data_ack", {63'd0, a}, 64'd0);
    stop_c(); q();
    chk("t7_values", values, ev_bus());
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
